// File: rtl/display_mode_scheduler.sv
// Display metric sequencer: rotates MODE across enabled metrics with a timed dwell,
// an optional dark gap between metrics, manual advance, hold, and skipping of disabled metrics.
module display_mode_scheduler #(
    parameter int unsigned DWELL_TICKS = 2000,
    parameter int unsigned BLANK_TICKS = 50
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       tick,
    input  logic [3:0] mode_en,
    input  logic       next_req,
    input  logic       hold,
    output logic [1:0] MODE,
    output logic       blank,
    output logic       mode_strobe
);

    localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int unsigned BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

    localparam logic [0:0] S_SHOW  = 1'b0;
    localparam logic [0:0] S_BLANK = 1'b1;

    logic [0:0]    state;
    logic [DW-1:0] dwellCnt;
    logic [BW-1:0] blankCnt;
    logic [1:0]    target;

    logic [1:0]    nextMode;
    logic [1:0]    cand;
    logic          found;
    logic          countTick;
    logic          advance;

    // First enabled metric after MODE in wrap-around order; MODE itself if none, 0 if all disabled.
    always_comb begin
        nextMode = MODE;
        cand     = '0;
        found    = 1'b0;
        for (int unsigned k = 1; k < 4; k++) begin
            cand = MODE + 2'(k);
            if (!found && mode_en[cand]) begin
                nextMode = cand;
                found    = 1'b1;
            end
        end
        if (mode_en == '0) begin
            nextMode = '0;
        end
    end

    always_comb begin
        countTick = tick && !hold;
        advance   = (countTick && (dwellCnt == DWELL_LAST))
                 || next_req
                 || ((mode_en != '0) && !mode_en[MODE]);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= S_SHOW;
            MODE        <= '0;
            blank       <= 1'b0;
            mode_strobe <= 1'b0;
            dwellCnt    <= '0;
            blankCnt    <= '0;
            target      <= '0;
        end else begin
            mode_strobe <= 1'b0;
            case (state)
                S_SHOW: begin
                    if (advance) begin
                        // An advancing tick is consumed by the advance, never counted toward the new dwell.
                        dwellCnt <= '0;
                        if (nextMode != MODE) begin
                            if (BLANK_TICKS == 0) begin
                                MODE        <= nextMode;
                                mode_strobe <= 1'b1;
                            end else begin
                                target   <= nextMode;
                                blank    <= 1'b1;
                                blankCnt <= '0;
                                state    <= S_BLANK;
                            end
                        end
                    end else if (countTick) begin
                        dwellCnt <= dwellCnt + 1'b1;
                    end
                end
                S_BLANK: begin
                    if (tick) begin
                        if (blankCnt == BLANK_LAST) begin
                            MODE        <= target;
                            blank       <= 1'b0;
                            mode_strobe <= 1'b1;
                            dwellCnt    <= '0;
                            state       <= S_SHOW;
                        end else begin
                            blankCnt <= blankCnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_SHOW;
                end
            endcase
        end
    end

endmodule
